switch_debouncer: RTL and testbench

Upstream conditioning stage for the memory-mapped switch device. It takes the raw board slide-switch vector, synchronises it into the `clk` domain, and filters contact bounce. It presents the switch device's `value` input with a debounced vector that changes at most once per settled transition, plus a one-cycle change strobe. The switch device's change detection, `ready` and `overrun` logic therefore only ever see genuine, settled transitions.

---
 rtl/switch_debouncer.sv | 117 +++++++++++
 tb/tb_switch_debouncer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// Switch debouncer: synchronises a raw slide-switch vector into clk_i and commits
// a new value only after it has held for DEBOUNCE_CYCLES cycles. SWDEB_SYNC3_EN selects a 3-stage synchroniser.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | synchronised input matches sw_stable_o, nothing to qualify
// COUNT  | a candidate differing from sw_stable_o is being qualified
module switch_debouncer #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 10000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] sw_raw_i,
    output logic [WIDTH-1:0] sw_stable_o,
    output logic             changed_o,
    output logic             busy_o
);

`ifdef SWDEB_SYNC3_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_COUNT = 1'b1;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic             changed_q, changed_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= sw_raw_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Abort has priority over restart, restart over commit: a bounce back to the
    // committed value on the commit edge must not produce a strobe.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        stable_d  = stable_q;
        changed_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sync != stable_q) begin
                    cand_d  = sync;
                    cnt_d   = CNT_ONE;
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (sync == stable_q) begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_IDLE;
                end else if (sync != cand_q) begin
                    cand_d = sync;
                    cnt_d  = CNT_ONE;
                end else if (cnt_q == CNT_MAX) begin
                    stable_d  = cand_q;
                    changed_d = 1'b1;
                    cnt_d     = CNT_ZERO;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            cand_q    <= '0;
            cnt_q     <= CNT_ZERO;
            stable_q  <= '0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            changed_q <= changed_d;
        end
    end

    assign sw_stable_o = stable_q;
    assign changed_o   = changed_q;
    assign busy_o      = (state_q == ST_COUNT);

endmodule

// File: tb/tb_switch_debouncer.sv
// Testbench for switch_debouncer (DEBOUNCE_CYCLES = 4): expected commits are queued
// when stimulus is driven and matched against each changed_o strobe.
module tb_switch_debouncer;

    localparam int WIDTH = 10;
    localparam int DEB   = 4;
`ifdef SWDEB_SYNC3_EN
    localparam int X = 1;
`else
    localparam int X = 0;
`endif

    typedef struct {
        logic [WIDTH-1:0] val;
        int               edge_n;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_stable;
    logic             changed;
    logic             busy;

    int               n_tests = 0;
    int               n_fail  = 0;
    int               edge_cnt = 0;
    int               base;
    exp_t             sb_q[$];
    logic [WIDTH-1:0] exp_stable = '0;

    switch_debouncer #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk_i       (clk),
        .reset_i     (rst),
        .sw_raw_i    (sw_raw),
        .sw_stable_o (sw_stable),
        .changed_o   (changed),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] v, input int e);
        exp_t t;
        t.val    = v;
        t.edge_n = e;
        sb_q.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every strobe must match the head of the queue.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            exp_stable = '0;
            check_eq("rst_stable", 32'(sw_stable), 32'h0);
            check_eq("rst_changed", 32'(changed), 32'h0);
        end else if (changed) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_strobe", 32'(sw_stable), 32'(exp_stable));
                check_eq("unexpected_strobe_flag", 32'(changed), 32'h0);
            end else begin
                e = sb_q.pop_front();
                check_eq("commit_edge", 32'(edge_cnt), 32'(e.edge_n));
                check_eq("commit_val", 32'(sw_stable), 32'(e.val));
                exp_stable = e.val;
            end
        end else begin
            check_eq("stable_hold", 32'(sw_stable), 32'(exp_stable));
        end
    end

    task automatic step_to(input logic [WIDTH-1:0] v);
        @(negedge clk);
        base   = edge_cnt;
        sw_raw = v;
        push_exp(v, base + DEB + 3 + X);
        repeat (DEB + 8) tick();
    endtask

    initial begin
        rst    = 1'b1;
        sw_raw = '0;
        #12;
        check_eq("reset_stable", 32'(sw_stable), 32'h0);
        check_eq("reset_changed", 32'(changed), 32'h0);
        check_eq("reset_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();

        // clean step 0 -> 001
        @(negedge clk);
        base   = edge_cnt;
        sw_raw = 10'h001;
        push_exp(10'h001, base + 7 + X);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_eq("clean_busy", 32'(busy), 32'((i >= 3 + X) && (i <= 6 + X)));
        end
        repeat (4) tick();
        step_to(10'h000);

        // glitch reject: 004 for two cycles
        @(negedge clk);
        base = edge_cnt;
        for (int i = 1; i <= 10; i++) begin
            sw_raw = (i <= 2) ? 10'h004 : 10'h000;
            tick();
            if (i >= 3 + X && i <= 5 + X)
                check_eq("glitch_busy", 32'(busy), 32'(i <= 4 + X));
            @(negedge clk);
        end

        // bounce: toggles for 5 cycles, last change before edge 5, then hold
        base = edge_cnt;
        push_exp(10'h001, base + 5 + DEB + 2 + X);
        for (int i = 1; i <= 16; i++) begin
            sw_raw = (i >= 6 || (i % 2) == 1) ? 10'h001 : 10'h000;
            tick();
            @(negedge clk);
        end
        step_to(10'h000);

        // abort coincides with the would-be commit edge
        @(negedge clk);
        base = edge_cnt;
        for (int i = 1; i <= 12; i++) begin
            sw_raw = (i <= 4) ? 10'h001 : 10'h000;
            tick();
            if (i == 6 + X) check_eq("collide_busy_pre", 32'(busy), 32'h1);
            if (i == 7 + X) check_eq("collide_busy_post", 32'(busy), 32'h0);
            @(negedge clk);
        end

        // multi-bit: bit 0 before edge 1, bit 9 before edge 3
        base = edge_cnt;
        push_exp(10'h201, base + 9 + X);
        for (int i = 1; i <= 14; i++) begin
            sw_raw = (i <= 2) ? 10'h001 : 10'h201;
            tick();
            @(negedge clk);
        end

        // asynchronous reset mid-COUNT, then requalify from 0
        sw_raw = 10'h3FF;
        repeat (4) tick();
        check_eq("pre_reset_busy", 32'(busy), 32'h1);
        check_eq("pre_reset_stable", 32'(sw_stable), 32'h201);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_stable", 32'(sw_stable), 32'h0);
        check_eq("async_rst_changed", 32'(changed), 32'h0);
        check_eq("async_rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        base = edge_cnt;
        push_exp(10'h3FF, base + 7 + X);
        repeat (12) tick();

        check_eq("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
